// File: rtl/ecc_apb_cmd_master.sv
// APB command master for the ECC block: takes one job per handshake, writes DATA_IN/NOISE/WIDTH/CTRL, then waits for done or a timeout.
// Define ECC_APB_READBACK_EN to read back and compare each configuration write; a mismatch sets rsp_cfg_err.
module ecc_apb_cmd_master #(
  parameter int AMBA_ADDR_WIDTH = 32,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [1:0]                 cmd_width,
  input  logic [DATA_WIDTH-1:0]      cmd_data,
  input  logic [DATA_WIDTH-1:0]      cmd_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] paddr,
  output logic [AMBA_WORD-1:0]       pwdata,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  input  logic [AMBA_WORD-1:0]       prdata,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_errors,
  output logic                       rsp_timeout,
  output logic                       rsp_cfg_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_DONE, RESP} state_t;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d, op_q, op_d, width_q, width_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, noise_q, noise_d, rdata_q, rdata_d;
  logic [1:0]            rerr_q, rerr_d;
  logic                  rto_q, rto_d, rcfg_q, rcfg_d, rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            addr;
  logic [AMBA_WORD-1:0]  wval;

`ifndef ECC_APB_READBACK_EN
  logic unused_prdata;
  assign unused_prdata = ^prdata;
`endif

  // Write order is DATA_IN, NOISE, CODEWORD_WIDTH, CTRL; the CTRL write launches the job.
  always_comb begin
    addr = 8'h00;
    wval = '0;
    case (idx_q)
      2'd0: begin addr = 8'h04; wval = AMBA_WORD'(data_q);  end
      2'd1: begin addr = 8'h0C; wval = AMBA_WORD'(noise_q); end
      2'd2: begin addr = 8'h08; wval = AMBA_WORD'(width_q); end
      default: begin addr = 8'h00; wval = AMBA_WORD'(op_q); end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      width_q <= '0;
      data_q  <= '0;
      noise_q <= '0;
      rdata_q <= '0;
      rerr_q  <= '0;
      rto_q   <= 1'b0;
      rcfg_q  <= 1'b0;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      width_q <= width_d;
      data_q  <= data_d;
      noise_q <= noise_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      rto_q   <= rto_d;
      rcfg_q  <= rcfg_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    width_d   = width_q;
    data_d    = data_q;
    noise_d   = noise_q;
    rdata_d   = rdata_q;
    rerr_d    = rerr_q;
    rto_d     = rto_q;
    rcfg_d    = rcfg_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    pwrite    = 1'b0;
    paddr     = '0;
    pwdata    = '0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          width_d = cmd_width;
          data_d  = cmd_data;
          noise_d = cmd_noise;
          idx_d   = '0;
          rd_d    = 1'b0;
          rcfg_d  = 1'b0;
          if (cmd_op == 2'd3 || cmd_width == 2'd3) begin
            rcfg_d  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        psel    = 1'b1;
        pwrite  = ~rd_q;
        paddr   = AMBA_ADDR_WIDTH'(addr);
        pwdata  = wval;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = ~rd_q;
        paddr   = AMBA_ADDR_WIDTH'(addr);
        pwdata  = wval;
`ifdef ECC_APB_READBACK_EN
        if (rd_q) begin
          if (prdata != wval) rcfg_d = 1'b1;
          rd_d    = 1'b0;
          idx_d   = idx_q + 2'd1;
          state_d = SETUP;
        end else if (idx_q != 2'd3) begin
          rd_d    = 1'b1;
          state_d = SETUP;
        end else begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end
`else
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          state_d = SETUP;
        end else begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end
`endif
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        // Done takes priority over a timeout in the same cycle.
        if (operation_done) begin
          rdata_d = data_out;
          rerr_d  = num_of_errors;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rto_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rdata_d = '0;
          rerr_d  = '0;
          rto_d   = 1'b0;
          rcfg_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid   = (state_q == RESP);
  assign rsp_data    = rdata_q;
  assign rsp_errors  = rerr_q;
  assign rsp_timeout = rto_q;
  assign rsp_cfg_err = rcfg_q;
endmodule

// File: tb/tb_ecc_apb_cmd_master.sv
// Directed self-checking bench for ecc_apb_cmd_master, with a small APB register model that answers readbacks.
module tb_ecc_apb_cmd_master;
  localparam int TO = 16;
`ifdef ECC_APB_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 0, cmd_ready;
  logic [1:0]  cmd_op = 0, cmd_width = 0;
  logic [31:0] cmd_data = 0, cmd_noise = 0;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite;
  logic        operation_done = 0;
  logic [31:0] data_out = 32'hFFFF_FFFF;
  logic [1:0]  num_of_errors = 2'd3;
  logic        rsp_valid, rsp_ready = 0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_errors;
  logic        rsp_timeout, rsp_cfg_err;

  int checks = 0, failures = 0;
  bit corrupt = 0;
  logic [31:0] mem [4];

  ecc_apb_cmd_master #(.AMBA_ADDR_WIDTH(32), .AMBA_WORD(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_width(cmd_width), .cmd_data(cmd_data), .cmd_noise(cmd_noise), .paddr(paddr),
    .pwdata(pwdata), .psel(psel), .penable(penable), .pwrite(pwrite), .prdata(prdata),
    .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_errors(rsp_errors),
    .rsp_timeout(rsp_timeout), .rsp_cfg_err(rsp_cfg_err));

  always #5 clk = ~clk;

  always @(posedge clk) if (psel && penable && pwrite) mem[paddr[3:2]] <= pwdata;
  assign prdata = mem[paddr[3:2]] ^ ((corrupt && paddr[3:0] == 4'hC && !pwrite) ? 32'h1 : 32'h0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input logic [1:0] op, input logic [1:0] width, input logic [31:0] data,
                         input logic [31:0] noise, input int done_at, input logic [31:0] dout,
                         input logic [1:0] nerr, input int hold, input bit corr);
    bit rsv, to, ecfg;
    logic [31:0] edata, wv [4], av [4];
    logic [1:0]  eerr;
    rsv  = (op == 2'd3) || (width == 2'd3);
    to   = !rsv && done_at < 0;
    ecfg = rsv || (RB && corr);
    edata = (rsv || to) ? 32'h0 : dout;
    eerr  = (rsv || to) ? 2'd0 : nerr;
    wv = '{data, noise, {30'b0, width}, {30'b0, op}};
    av = '{32'h04, 32'h0C, 32'h08, 32'h00};
    corrupt = corr;
    @(negedge clk);
    cmd_op = op; cmd_width = width; cmd_data = data; cmd_noise = noise; cmd_valid = 1;
    check("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
    if (!rsv) begin
      for (int i = 0; i < 4; i++) begin
        for (int p = 0; p < ((RB && i < 3) ? 4 : 2); p++) begin
          check("psel_apb", psel, 1);
          check("penable_apb", penable, p % 2);
          check("pwrite_apb", pwrite, p < 2);
          check("paddr_apb", paddr, av[i]);
          if (p < 2) check("pwdata_apb", pwdata, wv[i]);
          @(negedge clk);
        end
      end
      for (int w = 0; w < TO; w++) begin
        check("psel_wait", psel, 0);
        check("rsp_valid_wait", rsp_valid, 0);
        if (w == done_at) begin
          operation_done = 1; data_out = dout; num_of_errors = nerr;
          @(negedge clk);
          operation_done = 0; data_out = 32'hFFFF_FFFF; num_of_errors = 2'd3;
          break;
        end
        if (w == TO - 1) @(negedge clk);
        else @(negedge clk);
      end
    end else begin
      check("psel_rsv", psel, 0);
    end
    check("rsp_valid", rsp_valid, 1);
    check("cmd_ready_resp", cmd_ready, 0);
    for (int h = 0; h <= hold; h++) begin
      check("rsp_data", rsp_data, edata);
      check("rsp_errors", rsp_errors, eerr);
      check("rsp_timeout", rsp_timeout, to);
      check("rsp_cfg_err", rsp_cfg_err, ecfg);
      check("rsp_valid_hold", rsp_valid, 1);
      check("psel_resp", psel, 0);
      if (h < hold) @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("rsp_valid_clr", rsp_valid, 0);
    check("cmd_ready_back", cmd_ready, 1);
    check("flags_clr", {rsp_timeout, rsp_cfg_err, rsp_errors}, 0);
    check("rsp_data_clr", rsp_data, 0);
    corrupt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_apb", {psel, penable, pwrite}, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp", {rsp_valid, rsp_timeout, rsp_cfg_err, rsp_errors}, 0);
    check("rst_rsp_data", rsp_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    run_job(2'd0, 2'd0, 32'hA5, 32'h0, 3, 32'h1A5, 2'd0, 0, 0);
    run_job(2'd1, 2'd2, 32'h1234_5678, 32'h0000_0100, 5, 32'h1234_5678, 2'd1, 5, 0);
    run_job(2'd2, 2'd1, 32'h0000_BEEF, 32'h0, -1, 32'h0, 2'd0, 0, 0);
    run_job(2'd0, 2'd1, 32'h0000_BEEF, 32'h0, 0, 32'h0001_BEEF, 2'd2, 0, 0);
    run_job(2'd1, 2'd0, 32'h3C, 32'h2, TO - 1, 32'h3E, 2'd1, 0, 0);
    run_job(2'd3, 2'd0, 32'h11, 32'h0, 0, 32'h11, 2'd0, 2, 0);
    run_job(2'd0, 2'd3, 32'h22, 32'h0, 0, 32'h22, 2'd0, 0, 0);

    // Reset during the CODEWORD_WIDTH write, then a stray done.
    @(negedge clk);
    cmd_op = 2'd1; cmd_width = 2'd2; cmd_data = 32'h55; cmd_noise = 32'h4; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    repeat (RB ? 8 : 4) @(negedge clk);
    check("pre_rst_paddr", paddr, 32'h08);
    check("pre_rst_psel", psel, 1);
    #1 rst = 1;
    #1;
    check("mid_rst_apb", {psel, penable}, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 0;
    operation_done = 1; data_out = 32'h77;
    @(negedge clk);
    operation_done = 0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid || psel) seen = 1;
      @(negedge clk);
    end
    check("no_rsp_after_rst", seen, 0);
    check("cmd_ready_after_rst", cmd_ready, 1);

    run_job(2'd0, 2'd2, 32'hCAFE_F00D, 32'h8000_0000, 2, 32'hCAFE_F00D, 2'd0, 0, 0);
    run_job(2'd1, 2'd2, 32'h0F0F_0F0F, 32'h0000_0010, 1, 32'h0F0F_0F0F, 2'd1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ecc_apb_cmd_master.md
Name: ecc_apb_cmd_master

Overview:
- Upstream command sequencer for the ECC encoder/decoder.
- Accepts one ECC job per valid/ready handshake and issues the APB register writes that configure and launch the job.
- Waits for operation_done, then captures data_out and num_of_errors into a held response.
- Replaces hand-written APB stimulus with a reusable master usable in system and block benches.

Parameters:
AMBA_ADDR_WIDTH, 32, APB address width
AMBA_WORD, 32, APB data width
DATA_WIDTH, 32, ECC data/codeword width
TIMEOUT_CYCLES, 1024, max cycles waiting for operation_done

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  job request
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  0 encode, 1 decode, 2 full channel, 3 reserved
cmd_width  in  2  0 = 8b, 1 = 16b, 2 = 32b codeword, 3 reserved
cmd_data  in  DATA_WIDTH  data/codeword
cmd_noise  in  DATA_WIDTH  noise vector
paddr  out  AMBA_ADDR_WIDTH  APB address
pwdata  out  AMBA_WORD  APB write data
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
prdata  in  AMBA_WORD  APB read data (used only with option)
operation_done  in  1  ECC completion pulse
data_out  in  DATA_WIDTH  ECC result
num_of_errors  in  2  ECC error count
rsp_valid  out  1  response held
rsp_ready  in  1  response accepted
rsp_data  out  DATA_WIDTH  captured data_out
rsp_errors  out  2  captured num_of_errors
rsp_timeout  out  1  no done within TIMEOUT_CYCLES
rsp_cfg_err  out  1  reserved op/width, or readback mismatch

Behaviour:
- Register map, byte addresses: CTRL 0x00, DATA_IN 0x04, CODEWORD_WIDTH 0x08, NOISE 0x0C.
- Write order: DATA_IN, NOISE, CODEWORD_WIDTH, then CTRL. The CTRL write launches the job.
- Reset: all outputs 0 except cmd_ready = 1. FSM goes to IDLE, counters clear. The same applies mid-transfer: psel/penable drop in the same cycle rst asserts, and no partial response is produced.
- States: IDLE, SETUP, ACCESS, WAIT_DONE, RESP.
- IDLE: on cmd_valid && cmd_ready, latch cmd_* and clear write index. Valid op/width -> SETUP. Reserved op or width -> RESP with rsp_cfg_err = 1, rsp_data = 0, no APB activity.
- SETUP: psel = 1, penable = 0, pwrite = 1; paddr/pwdata from the write index. Next state is ACCESS.
- ACCESS: psel = 1, penable = 1, paddr/pwdata unchanged. No pready, so ACCESS lasts exactly 1 cycle. Write index < 3: increment and go to SETUP. Otherwise go to WAIT_DONE.
- Between writes psel stays 1; penable toggles every cycle.
- CTRL write data = {30'b0, cmd_op}. CODEWORD_WIDTH write data = {30'b0, cmd_width}. DATA_IN and NOISE carry cmd_data/cmd_noise zero-extended to AMBA_WORD.
- Latency: handshake at cycle 0; APB writes occupy cycles 1-8; WAIT_DONE from cycle 9.
- WAIT_DONE: psel = 0, penable = 0. Timeout counter starts at 0 and increments each cycle. operation_done sampled high -> capture data_out/num_of_errors, go to RESP; rsp_valid rises the following cycle. Counter reaching TIMEOUT_CYCLES-1 without done -> RESP with rsp_timeout = 1 and rsp_data/rsp_errors = 0. Done and timeout in the same cycle: done wins.
- operation_done asserted outside WAIT_DONE is ignored.
- RESP: rsp_* stable while rsp_valid = 1. On rsp_ready go to IDLE; rsp_valid clears next cycle and flags clear. Back-to-back jobs: the earliest next handshake is the cycle after RESP exits.

Optional Feature:
- Macro ECC_APB_READBACK_EN.
- Defined: after each DATA_IN, NOISE and CODEWORD_WIDTH write, the master issues a 2-cycle APB read (pwrite = 0) of the same address and compares prdata to the written value.
- Any mismatch sets sticky rsp_cfg_err for that job; the job still launches. APB phase grows to 14 cycles, so WAIT_DONE begins at cycle 15.
- Undefined: writes only, prdata ignored; rsp_cfg_err is set only for reserved op/width.

Test Plan:
- Encode: op = 0, width = 0, data = 0xA5. Response: exactly 8 APB cycles at 0x04, 0x0C, 0x08, 0x00 with pwdata 0xA5, noise, 0, 0; psel/penable sequence correct. done with data_out = 0x1A5 -> rsp_data = 0x1A5, rsp_errors = 0.
- Decode with a 1-bit noise flip, width = 2. DUT returns num_of_errors = 1 -> rsp_errors = 1, rsp_timeout = 0. Hold rsp_ready low 5 cycles -> rsp_* stable throughout.
- Never assert operation_done, TIMEOUT_CYCLES = 16. rsp_timeout = 1 exactly 16 cycles after WAIT_DONE entry. The next job then runs normally.
- cmd_op = 3 -> no psel for the whole job; rsp_valid with rsp_cfg_err = 1 within 2 cycles.
- Assert rst during the 3rd APB write. psel/penable/rsp_valid go to 0 immediately and cmd_ready = 1. A spurious operation_done afterwards gives no response.
- With ECC_APB_READBACK_EN, corrupt prdata on the NOISE readback -> rsp_cfg_err = 1 and the CTRL write still issued. Without the macro, the same stimulus gives rsp_cfg_err = 0.
